pipeline_mutex_holder: RTL and testbench

//  Sequential owner of the register/memory/eflags mutex vectors that the read stage checks.

---
 rtl/pipeline_mutex_holder.sv | 98 +++++++++
 tb/tb_pipeline_mutex_holder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_mutex_holder.sv
// Purpose : carries the read-stage mutex vector through execute and write, releasing it on
//           retire, partial release or flush; exposes per-stage vectors to the hazard checker.
// Latency : 1 cycle, every output is a register (or a pure OR of registers).
// Backpr. : none; the stage handshakes are trusted, and misuse only raises a sticky error flag.
// Ports   : clk, rst_n                       clock / async active-low reset
//           rd_mutex_next, rd_ready          vector and transfer strobe from read into execute
//           exe_ready, wr_finished           execute->write transfer, write retire
//           wr_release_memory/esp            early drop of memory / esp bits held by write
//           exe_reset, wr_reset              flush execute only / flush execute and write
//           exe_mutex, wr_mutex              vectors held by execute / write
//           mutex_busy_any                   either stage occupied
//           mutex_protocol_err               sticky handshake-violation flag
module pipeline_mutex_holder #(
   parameter int MUTEX_W    = 11,
   parameter int ACTIVE_BIT = 10,
   parameter int MEMORY_BIT = 9,
   parameter int ESP_BIT    = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [MUTEX_W-1:0] rd_mutex_next,
   input  logic               rd_ready,
   input  logic               exe_ready,
   input  logic               wr_finished,
   input  logic               wr_release_memory,
   input  logic               wr_release_esp,
   input  logic               exe_reset,
   input  logic               wr_reset,
   output logic [MUTEX_W-1:0] exe_mutex,
   output logic [MUTEX_W-1:0] wr_mutex,
   output logic               mutex_busy_any,
   output logic               mutex_protocol_err
);

   logic [MUTEX_W-1:0] exe_mutex_nxt;
   logic [MUTEX_W-1:0] wr_mutex_nxt;
   logic               exe_act;
   logic               wr_act;
   logic               err_set;

   assign exe_act = exe_mutex[ACTIVE_BIT];
   assign wr_act  = wr_mutex[ACTIVE_BIT];

   // Execute stage: a new load wins over a same-cycle hand-off to write.
   always_comb begin
      exe_mutex_nxt = exe_mutex;
      if (wr_reset || exe_reset) begin
         exe_mutex_nxt = '0;
      end else if (rd_ready) begin
         exe_mutex_nxt             = rd_mutex_next;
         exe_mutex_nxt[ACTIVE_BIT] = 1'b1;
      end else if (exe_ready) begin
         exe_mutex_nxt = '0;
      end
   end

   // Write stage: an incoming vector replaces a retiring one. Partial releases only apply
   // while holding, and never touch the active bit.
   always_comb begin
      wr_mutex_nxt = wr_mutex;
      if (wr_reset) begin
         wr_mutex_nxt = '0;
      end else if (exe_ready) begin
         wr_mutex_nxt = exe_mutex;
      end else if (wr_finished) begin
         wr_mutex_nxt = '0;
      end else if (wr_act) begin
         if (wr_release_memory) wr_mutex_nxt[MEMORY_BIT] = 1'b0;
         if (wr_release_esp)    wr_mutex_nxt[ESP_BIT]    = 1'b0;
      end
   end

   // Handshake violations; a full flush masks everything seen in its cycle.
   always_comb begin
      err_set = 1'b0;
      if (!wr_reset) begin
         err_set = (rd_ready && exe_act && !exe_ready && !exe_reset) ||
                   (exe_ready && !exe_act) ||
                   (exe_ready && wr_act && !wr_finished) ||
                   (wr_finished && !wr_act);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exe_mutex          <= '0;
         wr_mutex           <= '0;
         mutex_protocol_err <= 1'b0;
      end else begin
         exe_mutex          <= exe_mutex_nxt;
         wr_mutex           <= wr_mutex_nxt;
         mutex_protocol_err <= mutex_protocol_err | err_set;
      end
   end

   assign mutex_busy_any = exe_act | wr_act;

endmodule

// File: tb/tb_pipeline_mutex_holder.sv
module tb_pipeline_mutex_holder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [10:0] rd_mutex_next = '0;
   logic        rd_ready = 1'b0;
   logic        exe_ready = 1'b0;
   logic        wr_finished = 1'b0;
   logic        wr_release_memory = 1'b0;
   logic        wr_release_esp = 1'b0;
   logic        exe_reset = 1'b0;
   logic        wr_reset = 1'b0;
   logic [10:0] exe_mutex;
   logic [10:0] wr_mutex;
   logic        mutex_busy_any;
   logic        mutex_protocol_err;

   int assert_cnt = 0;
   int fail_cnt   = 0;

   pipeline_mutex_holder dut (
      .clk(clk), .rst_n(rst_n),
      .rd_mutex_next(rd_mutex_next), .rd_ready(rd_ready), .exe_ready(exe_ready),
      .wr_finished(wr_finished), .wr_release_memory(wr_release_memory),
      .wr_release_esp(wr_release_esp), .exe_reset(exe_reset), .wr_reset(wr_reset),
      .exe_mutex(exe_mutex), .wr_mutex(wr_mutex),
      .mutex_busy_any(mutex_busy_any), .mutex_protocol_err(mutex_protocol_err)
   );

   always #5 clk = ~clk;

   // Advance one rising edge, then settle so outputs are sampled away from the edge;
   // all strobes return to idle afterwards.
   task automatic cycle();
      @(posedge clk);
      #1;
      rd_ready = 0; exe_ready = 0; wr_finished = 0; wr_release_memory = 0;
      wr_release_esp = 0; exe_reset = 0; wr_reset = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      #3;
      assert_cnt++; if (exe_mutex !== 11'h000) begin fail_cnt++; $display("FAIL reset_exe: got %h exp 000", exe_mutex); end
      assert_cnt++; if (wr_mutex !== 11'h000) begin fail_cnt++; $display("FAIL reset_wr: got %h exp 000", wr_mutex); end
      assert_cnt++; if (mutex_busy_any !== 1'b0) begin fail_cnt++; $display("FAIL reset_busy: got %b exp 0", mutex_busy_any); end
      assert_cnt++; if (mutex_protocol_err !== 1'b0) begin fail_cnt++; $display("FAIL reset_err: got %b exp 0", mutex_protocol_err); end
      @(negedge clk);
      rst_n = 1;
      cycle();
   endtask

   task automatic test_load();
      rd_ready = 1; rd_mutex_next = 11'h201;
      cycle();
      assert_cnt++; if (exe_mutex !== 11'h601) begin fail_cnt++; $display("FAIL load_exe: got %h exp 601", exe_mutex); end
      assert_cnt++; if (wr_mutex !== 11'h000) begin fail_cnt++; $display("FAIL load_wr: got %h exp 000", wr_mutex); end
      assert_cnt++; if (mutex_busy_any !== 1'b1) begin fail_cnt++; $display("FAIL load_busy: got %b exp 1", mutex_busy_any); end
   endtask

   task automatic test_transfer_retire();
      cycle();  // hold
      assert_cnt++; if (exe_mutex !== 11'h601) begin fail_cnt++; $display("FAIL hold_exe: got %h exp 601", exe_mutex); end
      exe_ready = 1;
      cycle();
      assert_cnt++; if (exe_mutex !== 11'h000) begin fail_cnt++; $display("FAIL xfer_exe: got %h exp 000", exe_mutex); end
      assert_cnt++; if (wr_mutex !== 11'h601) begin fail_cnt++; $display("FAIL xfer_wr: got %h exp 601", wr_mutex); end
      assert_cnt++; if (mutex_busy_any !== 1'b1) begin fail_cnt++; $display("FAIL xfer_busy: got %b exp 1", mutex_busy_any); end
      wr_finished = 1;
      cycle();
      assert_cnt++; if (wr_mutex !== 11'h000) begin fail_cnt++; $display("FAIL retire_wr: got %h exp 000", wr_mutex); end
      assert_cnt++; if (mutex_busy_any !== 1'b0) begin fail_cnt++; $display("FAIL retire_busy: got %b exp 0", mutex_busy_any); end
      assert_cnt++; if (mutex_protocol_err !== 1'b0) begin fail_cnt++; $display("FAIL retire_err: got %b exp 0", mutex_protocol_err); end
   endtask

   task automatic test_back_to_back();
      rd_ready = 1; rd_mutex_next = 11'h010;
      cycle();
      assert_cnt++; if (exe_mutex !== 11'h410) begin fail_cnt++; $display("FAIL b2b_pre_exe: got %h exp 410", exe_mutex); end
      rd_ready = 1; exe_ready = 1; rd_mutex_next = 11'h008;
      cycle();
      assert_cnt++; if (exe_mutex !== 11'h408) begin fail_cnt++; $display("FAIL b2b_exe: got %h exp 408", exe_mutex); end
      assert_cnt++; if (wr_mutex !== 11'h410) begin fail_cnt++; $display("FAIL b2b_wr: got %h exp 410", wr_mutex); end
      assert_cnt++; if (mutex_protocol_err !== 1'b0) begin fail_cnt++; $display("FAIL b2b_err: got %b exp 0", mutex_protocol_err); end
   endtask

   task automatic test_partial_release();
      wr_reset = 1;
      cycle();
      assert_cnt++; if ({exe_mutex, wr_mutex} !== 22'h0) begin fail_cnt++; $display("FAIL pr_flush: got %h/%h exp 000/000", exe_mutex, wr_mutex); end
      // Release strobes with write empty must not create anything.
      wr_release_memory = 1; wr_release_esp = 1;
      cycle();
      assert_cnt++; if (wr_mutex !== 11'h000) begin fail_cnt++; $display("FAIL pr_empty_wr: got %h exp 000", wr_mutex); end
      rd_ready = 1; rd_mutex_next = 11'h210;
      cycle();
      exe_ready = 1;
      cycle();
      assert_cnt++; if (wr_mutex !== 11'h610) begin fail_cnt++; $display("FAIL pr_load_wr: got %h exp 610", wr_mutex); end
      wr_release_memory = 1;
      cycle();
      assert_cnt++; if (wr_mutex !== 11'h410) begin fail_cnt++; $display("FAIL pr_mem_wr: got %h exp 410", wr_mutex); end
      wr_release_esp = 1;
      cycle();
      assert_cnt++; if (wr_mutex !== 11'h400) begin fail_cnt++; $display("FAIL pr_esp_wr: got %h exp 400", wr_mutex); end
      rd_ready = 1; rd_mutex_next = 11'h001;
      cycle();
      assert_cnt++; if (exe_mutex !== 11'h401) begin fail_cnt++; $display("FAIL pr_rd_exe: got %h exp 401", exe_mutex); end
      assert_cnt++; if (mutex_protocol_err !== 1'b0) begin fail_cnt++; $display("FAIL pr_err: got %b exp 0", mutex_protocol_err); end
   endtask

   task automatic test_flush();
      wr_reset = 1;
      cycle();
      rd_ready = 1; rd_mutex_next = 11'h002;
      cycle();
      rd_ready = 1; exe_ready = 1; rd_mutex_next = 11'h001;
      cycle();
      assert_cnt++; if (exe_mutex !== 11'h401 || wr_mutex !== 11'h402) begin fail_cnt++; $display("FAIL fl_setup: got %h/%h exp 401/402", exe_mutex, wr_mutex); end
      exe_reset = 1;
      cycle();
      assert_cnt++; if (exe_mutex !== 11'h000) begin fail_cnt++; $display("FAIL fl_exe_exe: got %h exp 000", exe_mutex); end
      assert_cnt++; if (wr_mutex !== 11'h402) begin fail_cnt++; $display("FAIL fl_exe_wr: got %h exp 402", wr_mutex); end
      wr_reset = 1;
      cycle();
      assert_cnt++; if ({exe_mutex, wr_mutex} !== 22'h0) begin fail_cnt++; $display("FAIL fl_wr: got %h/%h exp 000/000", exe_mutex, wr_mutex); end
      // exe_reset with a same-cycle exe_ready still hands the vector to write.
      rd_ready = 1; rd_mutex_next = 11'h080;
      cycle();
      exe_reset = 1; exe_ready = 1;
      cycle();
      assert_cnt++; if (exe_mutex !== 11'h000 || wr_mutex !== 11'h480) begin fail_cnt++; $display("FAIL fl_exe_xfer: got %h/%h exp 000/480", exe_mutex, wr_mutex); end
      assert_cnt++; if (mutex_protocol_err !== 1'b0) begin fail_cnt++; $display("FAIL fl_err: got %b exp 0", mutex_protocol_err); end
      wr_reset = 1;
      cycle();
   endtask

   task automatic test_protocol_err();
      // Errors under wr_reset are masked.
      wr_finished = 1; exe_ready = 1; wr_reset = 1;
      cycle();
      assert_cnt++; if (mutex_protocol_err !== 1'b0) begin fail_cnt++; $display("FAIL pe_masked: got %b exp 0", mutex_protocol_err); end
      rd_ready = 1; rd_mutex_next = 11'h001;
      cycle();
      rd_ready = 1; rd_mutex_next = 11'h003;
      cycle();
      assert_cnt++; if (mutex_protocol_err !== 1'b1) begin fail_cnt++; $display("FAIL pe_overwrite: got %b exp 1", mutex_protocol_err); end
      assert_cnt++; if (exe_mutex !== 11'h403) begin fail_cnt++; $display("FAIL pe_exe: got %h exp 403", exe_mutex); end
      wr_reset = 1;
      cycle();
      assert_cnt++; if (mutex_protocol_err !== 1'b1) begin fail_cnt++; $display("FAIL pe_sticky: got %b exp 1", mutex_protocol_err); end
      #2;
      rst_n = 0;
      #1;
      assert_cnt++; if (mutex_protocol_err !== 1'b0 || exe_mutex !== 11'h000) begin fail_cnt++; $display("FAIL pe_async_rst: got %b/%h exp 0/000", mutex_protocol_err, exe_mutex); end
      @(negedge clk);
      rst_n = 1;
      cycle();
      // Retire while write is empty.
      wr_finished = 1;
      cycle();
      assert_cnt++; if (mutex_protocol_err !== 1'b1) begin fail_cnt++; $display("FAIL pe_retire_empty: got %b exp 1", mutex_protocol_err); end
      rst_n = 0; #2; rst_n = 1;
      cycle();
      // Hand-off from an empty execute stage.
      exe_ready = 1;
      cycle();
      assert_cnt++; if (mutex_protocol_err !== 1'b1) begin fail_cnt++; $display("FAIL pe_xfer_empty: got %b exp 1", mutex_protocol_err); end
      rst_n = 0; #2; rst_n = 1;
      cycle();
      // Hand-off onto an occupied write stage that is not retiring.
      rd_ready = 1; rd_mutex_next = 11'h001;
      cycle();
      rd_ready = 1; exe_ready = 1; rd_mutex_next = 11'h002;
      cycle();
      assert_cnt++; if (mutex_protocol_err !== 1'b0) begin fail_cnt++; $display("FAIL pe_pre_wr_ovr: got %b exp 0", mutex_protocol_err); end
      exe_ready = 1;
      cycle();
      assert_cnt++; if (mutex_protocol_err !== 1'b1 || wr_mutex !== 11'h402) begin fail_cnt++; $display("FAIL pe_wr_overwrite: got %b/%h exp 1/402", mutex_protocol_err, wr_mutex); end
   endtask

   initial begin
      test_reset();
      test_load();
      test_transfer_retire();
      test_back_to_back();
      test_partial_release();
      test_flush();
      test_protocol_err();
      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
